// File: rtl/arm_pipe_pkg.sv
// Shared types for the LEGv8 hazard controller: forwarding selects,
// the zero-register index and the shadow-stage record.
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam int unsigned ZERO_REG_IDX = 31;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       use_rn;
        logic       use_rm;
    } stage_info_t;

endpackage

// File: rtl/arm_hazard_match.sv
// Combinational "this shadow stage writes register r" compare.
// XZR writes never count as a producer.
module arm_hazard_match
    import arm_pipe_pkg::*;
#(
    parameter int unsigned ZERO_REG = ZERO_REG_IDX
) (
    input  logic       valid,
    input  logic       reg_write,
    input  logic [4:0] rd,
    input  logic [4:0] r,
    output logic       hit
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    assign hit = valid & reg_write & (rd == r) & (r != ZR);

endmodule

// File: rtl/arm_hazard_ctrl.sv
// Hazard/flush controller with EX/MEM/WB shadow scoreboard.
// HAZARD_FWD_EN selects forwarding + 1-cycle load-use stall.
module arm_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned ZERO_REG = ZERO_REG_IDX
) (
    input  logic             clk,
    input  logic             pc_reset_n,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_valid,
    input  logic             mem_branch_taken,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stage_info_t      ex_q, mem_q, wb_q;
    stage_info_t      ex_d, mem_d, wb_d, id_info;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall, flush;
    logic             ex_rn_hit, ex_rm_hit;
    logic             unused_bits;

    assign unused_bits = ^{ex_q, mem_q, wb_q};

    arm_hazard_match #(.ZERO_REG(ZERO_REG)) u_ex_rn (
        .valid(ex_q.valid), .reg_write(ex_q.reg_write),
        .rd(ex_q.rd), .r(id_rn), .hit(ex_rn_hit));
    arm_hazard_match #(.ZERO_REG(ZERO_REG)) u_ex_rm (
        .valid(ex_q.valid), .reg_write(ex_q.reg_write),
        .rd(ex_q.rd), .r(id_rm), .hit(ex_rm_hit));

`ifdef HAZARD_FWD_EN
    logic mem_a_hit, mem_b_hit, wb_a_hit, wb_b_hit;

    arm_hazard_match #(.ZERO_REG(ZERO_REG)) u_mem_a (
        .valid(mem_q.valid), .reg_write(mem_q.reg_write),
        .rd(mem_q.rd), .r(ex_q.rn), .hit(mem_a_hit));
    arm_hazard_match #(.ZERO_REG(ZERO_REG)) u_mem_b (
        .valid(mem_q.valid), .reg_write(mem_q.reg_write),
        .rd(mem_q.rd), .r(ex_q.rm), .hit(mem_b_hit));
    arm_hazard_match #(.ZERO_REG(ZERO_REG)) u_wb_a (
        .valid(wb_q.valid), .reg_write(wb_q.reg_write),
        .rd(wb_q.rd), .r(ex_q.rn), .hit(wb_a_hit));
    arm_hazard_match #(.ZERO_REG(ZERO_REG)) u_wb_b (
        .valid(wb_q.valid), .reg_write(wb_q.reg_write),
        .rd(wb_q.rd), .r(ex_q.rm), .hit(wb_b_hit));

    // A load in MEM only has its address, so it cannot forward from there.
    function automatic fwd_sel_e pick_fwd(logic en, logic mem_hit,
                                          logic mem_ld, logic wb_hit);
        pick_fwd = FWD_RF;
        if (en && mem_hit && !mem_ld) begin
            pick_fwd = FWD_MEM;
        end else if (en && wb_hit) begin
            pick_fwd = FWD_WB;
        end
    endfunction

    assign stall = id_valid & ex_q.mem_read &
                   ((id_use_rn & ex_rn_hit) | (id_use_rm & ex_rm_hit));
    assign fwd_a = pick_fwd(ex_q.valid & ex_q.use_rn, mem_a_hit,
                            mem_q.mem_read, wb_a_hit);
    assign fwd_b = pick_fwd(ex_q.valid & ex_q.use_rm, mem_b_hit,
                            mem_q.mem_read, wb_b_hit);
`else
    logic mem_rn_hit, mem_rm_hit, wb_rn_hit, wb_rm_hit;

    arm_hazard_match #(.ZERO_REG(ZERO_REG)) u_mem_rn (
        .valid(mem_q.valid), .reg_write(mem_q.reg_write),
        .rd(mem_q.rd), .r(id_rn), .hit(mem_rn_hit));
    arm_hazard_match #(.ZERO_REG(ZERO_REG)) u_mem_rm (
        .valid(mem_q.valid), .reg_write(mem_q.reg_write),
        .rd(mem_q.rd), .r(id_rm), .hit(mem_rm_hit));
    arm_hazard_match #(.ZERO_REG(ZERO_REG)) u_wb_rn (
        .valid(wb_q.valid), .reg_write(wb_q.reg_write),
        .rd(wb_q.rd), .r(id_rn), .hit(wb_rn_hit));
    arm_hazard_match #(.ZERO_REG(ZERO_REG)) u_wb_rm (
        .valid(wb_q.valid), .reg_write(wb_q.reg_write),
        .rd(wb_q.rd), .r(id_rm), .hit(wb_rm_hit));

    // No write-through in the register bank, so WB producers stall too.
    assign stall = id_valid &
                   ((id_use_rn & (ex_rn_hit | mem_rn_hit | wb_rn_hit)) |
                    (id_use_rm & (ex_rm_hit | mem_rm_hit | wb_rm_hit)));
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    assign flush = mem_branch_taken;

    always_comb begin
        id_info           = '0;
        id_info.valid     = id_valid;
        id_info.rd        = id_rd;
        id_info.reg_write = id_reg_write;
        id_info.mem_read  = id_mem_read;
        id_info.rn        = id_rn;
        id_info.rm        = id_rm;
        id_info.use_rn    = id_use_rn;
        id_info.use_rm    = id_use_rm;

        ex_d  = id_info;
        mem_d = ex_q;
        wb_d  = mem_q;
        if (flush) begin
            ex_d  = '0;
            mem_d = '0;
        end else if (stall) begin
            ex_d = '0;
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !flush && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_write_en   = flush | ~stall;
    assign ifid_write_en = flush | ~stall;
    assign ifid_flush    = flush;
    assign idex_bubble   = flush | stall;
    assign exmem_flush   = flush;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_arm_hazard_ctrl.sv
// Self-checking bench for arm_hazard_ctrl: directed pipeline scenarios
// plus a randomized run against an instruction-level reference model.
module tb_arm_hazard_ctrl;

    logic        clk = 1'b0;
    logic        pc_reset_n;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        id_use_rn, id_use_rm, id_reg_write, id_mem_read;
    logic        id_valid, mem_branch_taken;
    logic        pc_write_en, ifid_write_en, ifid_flush;
    logic        idex_bubble, exmem_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    arm_hazard_ctrl #(.CNT_W(16), .ZERO_REG(31)) dut (
        .clk(clk), .pc_reset_n(pc_reset_n),
        .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_valid(id_valid),
        .mem_branch_taken(mem_branch_taken),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Reference model: one instruction record per stage, 0=EX 1=MEM 2=WB.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
        int rn;
        int rm;
        bit urn;
        bit urm;
    } instr_t;

    instr_t pipe[3];
    int     exp_stalls, exp_flushes;

    function automatic bit writes(instr_t s, int r);
        return s.v && s.rw && s.rd == r && r != 31;
    endfunction

    function automatic bit model_stall();
        bit hz = 0;
`ifdef HAZARD_FWD_EN
        int depth = 1;
`else
        int depth = 3;
`endif
        for (int k = 0; k < depth; k++) begin
            if ((id_use_rn && writes(pipe[k], int'(id_rn))) ||
                (id_use_rm && writes(pipe[k], int'(id_rm)))) begin
                if (depth == 3 || pipe[k].mr) hz = 1;
            end
        end
        return id_valid && hz;
    endfunction

    function automatic logic [1:0] model_fwd(bit en, int src);
`ifdef HAZARD_FWD_EN
        if (!pipe[0].v || !en) return 2'b00;
        if (writes(pipe[1], src) && !pipe[1].mr) return 2'b10;
        if (writes(pipe[2], src)) return 2'b01;
        return 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    task automatic drive(input bit v, input int rn, input int rm,
                         input bit urn, input bit urm, input int rd,
                         input bit rw, input bit mr, input bit br);
        id_valid         = v;
        id_rn            = 5'(rn);
        id_rm            = 5'(rm);
        id_use_rn        = urn;
        id_use_rm        = urm;
        id_rd            = 5'(rd);
        id_reg_write     = rw;
        id_mem_read      = mr;
        mem_branch_taken = br;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        nop();
        pc_reset_n = 1'b0;
        step();
        pc_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        nop();
        pc_reset_n = 1'b0;
        #1;
        vectors++;
        if ({pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
             exmem_flush} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 11000",
                     {pc_write_en, ifid_write_en, ifid_flush,
                      idex_bubble, exmem_flush});
        end
        vectors++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_fwd got %b want 0000", {fwd_a, fwd_b});
        end
        vectors++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0",
                     stall_cnt, flush_cnt);
        end
        step();
        pc_reset_n = 1'b1;
    endtask

    // Producer followed by a dependent reader: count the stall cycles.
    task automatic test_raw_stall();
        int stalls = 0;
        int want;
        do_reset();
`ifdef HAZARD_FWD_EN
        drive(1, 2, 0, 1, 0, 1, 1, 1, 0);   // LDUR X1,[X2,#0]
        want = 1;
`else
        drive(1, 2, 3, 1, 1, 1, 1, 0, 0);   // ADD X1,X2,X3
        want = 3;
`endif
        #1;
        vectors++;
        if (pc_write_en !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_first got pc_we=%b want 1", pc_write_en);
        end
        step();
`ifdef HAZARD_FWD_EN
        drive(1, 1, 4, 1, 1, 3, 1, 0, 0);   // ADD X3,X1,X4
`else
        drive(1, 1, 1, 1, 1, 2, 1, 0, 0);   // ADD X2,X1,X1
`endif
        for (int i = 0; i < 8; i++) begin
            #1;
            if (pc_write_en) break;
            stalls++;
            vectors++;
            if (idex_bubble !== 1'b1 || ifid_write_en !== 1'b0) begin
                miscompares++;
                $display("FAIL raw_bubble got bub=%b ifid_we=%b want 1/0",
                         idex_bubble, ifid_write_en);
            end
            step();
        end
        vectors++;
        if (stalls != want) begin
            miscompares++;
            $display("FAIL raw_len got %0d want %0d", stalls, want);
        end
        vectors++;
        if (stall_cnt !== 16'(want)) begin
            miscompares++;
            $display("FAIL raw_cnt got %0d want %0d", stall_cnt, want);
        end
        step();
        nop();
        #1;
        vectors++;
`ifdef HAZARD_FWD_EN
        if ({fwd_a, fwd_b} !== 4'b0100) begin
            miscompares++;
            $display("FAIL raw_fwd got %b want 0100", {fwd_a, fwd_b});
        end
`else
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            miscompares++;
            $display("FAIL raw_fwd got %b want 0000", {fwd_a, fwd_b});
        end
`endif
        step();
    endtask

`ifdef HAZARD_FWD_EN
    task automatic test_fwd_paths();
        do_reset();
        drive(1, 2, 3, 1, 1, 1, 1, 0, 0);   // ADD X1,X2,X3
        step();
        drive(1, 1, 1, 1, 1, 5, 1, 0, 0);   // SUB X5,X1,X1
        #1;
        vectors++;
        if (pc_write_en !== 1'b1) begin
            miscompares++;
            $display("FAIL fwd_nostall got pc_we=%b want 1", pc_write_en);
        end
        step();
        nop();
        #1;
        vectors++;
        if ({fwd_a, fwd_b} !== 4'b1010) begin
            miscompares++;
            $display("FAIL fwd_mem got %b want 1010", {fwd_a, fwd_b});
        end
        step();
        drive(1, 2, 3, 1, 1, 1, 1, 0, 0);   // ADD X1
        step();
        nop();
        step();
        drive(1, 1, 7, 1, 1, 6, 1, 0, 0);   // ORR X6,X1,X7
        step();
        nop();
        #1;
        vectors++;
        if ({fwd_a, fwd_b} !== 4'b0100) begin
            miscompares++;
            $display("FAIL fwd_wb got %b want 0100", {fwd_a, fwd_b});
        end
        drive(1, 2, 3, 1, 1, 1, 1, 0, 0);   // ADD X1
        step();
        drive(1, 2, 3, 1, 1, 1, 1, 0, 0);   // ADD X1
        step();
        drive(1, 1, 7, 1, 1, 6, 1, 0, 0);   // ORR X6,X1,X7
        step();
        nop();
        #1;
        vectors++;
        if ({fwd_a, fwd_b} !== 4'b1000) begin
            miscompares++;
            $display("FAIL fwd_prio got %b want 1000", {fwd_a, fwd_b});
        end
        step();
    endtask
`endif

    task automatic test_flush_stall();
        do_reset();
`ifdef HAZARD_FWD_EN
        drive(1, 2, 0, 1, 0, 1, 1, 1, 0);
`else
        drive(1, 2, 3, 1, 1, 1, 1, 0, 0);
`endif
        step();
        drive(1, 1, 4, 1, 1, 3, 1, 0, 1);
        #1;
        vectors++;
        if ({pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
             exmem_flush} !== 5'b11111) begin
            miscompares++;
            $display("FAIL flush_ctrl got %b want 11111",
                     {pc_write_en, ifid_write_en, ifid_flush,
                      idex_bubble, exmem_flush});
        end
        step();
        drive(1, 1, 4, 1, 1, 3, 1, 0, 0);
        #1;
        vectors++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL flush_cnt got f=%0d s=%0d want 1/0",
                     flush_cnt, stall_cnt);
        end
        vectors++;
        if (pc_write_en !== 1'b1 || {fwd_a, fwd_b} !== 4'b0000) begin
            miscompares++;
            $display("FAIL flush_after got pc_we=%b fwd=%b want 1/0000",
                     pc_write_en, {fwd_a, fwd_b});
        end
        step();
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(1, 2, 3, 1, 1, 31, 1, 0, 0);  // ADD XZR,X2,X3
        step();
        drive(1, 31, 31, 1, 1, 6, 1, 0, 0);
        #1;
        vectors++;
        if (pc_write_en !== 1'b1) begin
            miscompares++;
            $display("FAIL xzr_stall got pc_we=%b want 1", pc_write_en);
        end
        step();
        nop();
        #1;
        vectors++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            miscompares++;
            $display("FAIL xzr_fwd got %b want 0000", {fwd_a, fwd_b});
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        drive(1, 2, 0, 1, 0, 1, 1, 1, 0);   // LDUR X1 (writer either way)
        step();
        drive(1, 1, 4, 1, 1, 3, 1, 0, 0);
        #1;
        vectors++;
        if (pc_write_en !== 1'b0 || flush_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL mid_pre got pc_we=%b f=%0d want 0/1",
                     pc_write_en, flush_cnt);
        end
        #2;
        pc_reset_n = 1'b0;
        #1;
        vectors++;
        if ({pc_write_en, ifid_write_en, idex_bubble, fwd_a, fwd_b}
            !== 7'b1100000 || flush_cnt !== 16'd0 ||
            stall_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL mid_reset got %b f=%0d s=%0d want 1100000/0/0",
                     {pc_write_en, ifid_write_en, idex_bubble,
                      fwd_a, fwd_b}, flush_cnt, stall_cnt);
        end
        step();
        pc_reset_n = 1'b1;
    endtask

    task automatic test_random();
        bit         st, fl, prev_st;
        logic [1:0] ea, eb;
        instr_t     id;
        do_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
        exp_stalls  = 0;
        exp_flushes = 0;
        prev_st     = 0;
        for (int n = 0; n < 400; n++) begin
            if (!prev_st) begin
                int r0 = $urandom_range(0, 4);
                int r1 = $urandom_range(0, 4);
                int r2 = $urandom_range(0, 4);
                drive($urandom_range(0, 3) != 0,
                      r0 == 4 ? 31 : r0, r1 == 4 ? 31 : r1,
                      1'($urandom), 1'($urandom),
                      r2 == 4 ? 31 : r2, 1'($urandom), 1'($urandom),
                      0);
            end
            mem_branch_taken = ($urandom_range(0, 7) == 0);
            #1;
            st = model_stall();
            fl = mem_branch_taken;
            ea = model_fwd(pipe[0].urn, pipe[0].rn);
            eb = model_fwd(pipe[0].urm, pipe[0].rm);
            vectors++;
            if ({pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
                 exmem_flush} !== {fl | !st, fl | !st, fl, fl | st, fl}) begin
                miscompares++;
                $display("FAIL rnd_ctrl n=%0d got %b want %b", n,
                         {pc_write_en, ifid_write_en, ifid_flush,
                          idex_bubble, exmem_flush},
                         {fl | !st, fl | !st, fl, fl | st, fl});
            end
            vectors++;
            if (fwd_a !== ea || fwd_b !== eb) begin
                miscompares++;
                $display("FAIL rnd_fwd n=%0d got %b/%b want %b/%b",
                         n, fwd_a, fwd_b, ea, eb);
            end
            vectors++;
            if (stall_cnt !== 16'(exp_stalls) ||
                flush_cnt !== 16'(exp_flushes)) begin
                miscompares++;
                $display("FAIL rnd_cnt n=%0d got %0d/%0d want %0d/%0d",
                         n, stall_cnt, flush_cnt, exp_stalls, exp_flushes);
            end
            id = '{v: id_valid, rd: int'(id_rd), rw: id_reg_write,
                   mr: id_mem_read, rn: int'(id_rn), rm: int'(id_rm),
                   urn: id_use_rn, urm: id_use_rm};
            step();
            if (fl) begin
                pipe[2]   = pipe[1];
                pipe[1].v = 0;
                pipe[0].v = 0;
                if (exp_flushes < 65535) exp_flushes++;
            end else if (st) begin
                pipe[2]   = pipe[1];
                pipe[1]   = pipe[0];
                pipe[0].v = 0;
                if (exp_stalls < 65535) exp_stalls++;
            end else begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = id;
            end
            prev_st = st && !fl;
        end
    endtask

    initial begin
        pc_reset_n = 1'b0;
        nop();
        #2;
        test_reset();
        test_raw_stall();
`ifdef HAZARD_FWD_EN
        test_fwd_paths();
`endif
        test_flush_stall();
        test_zero_reg();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
